ifetch_pq: RTL and testbench

Parametrised prefetching instruction-fetch stage that replaces the single-register fetch path. It keeps up to MAX_OUTSTANDING memory reads in flight, buffers returned instructions with their PCs in a FIFO_DEPTH-entry queue, and presents them to decode over a valid/ready handshake. A redirect from writeback flushes the queue and squashes in-flight responses, so the pipeline never sees a wrong-path instruction.

---
 rtl/ifetch_pq.sv | 156 +++++++++++++++
 tb/tb_ifetch_pq.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_pq.sv
// ifetch_pq: prefetching instruction-fetch stage.
// Keeps up to MAX_OUTSTANDING reads in flight, buffers returned words with
// their PCs in a FIFO_DEPTH-entry queue and hands them to decode over a
// valid/ready handshake. A redirect flushes the queue and squashes every
// response still owed by memory.
module ifetch_pq #(
    parameter int unsigned       XLEN            = 32,
    parameter int unsigned       BYTES_PER_WORD  = 4,
    parameter int unsigned       FIFO_DEPTH      = 4,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]   RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
);

    // Queue pointer width (FIFO_DEPTH is a power of two, so pointers wrap naturally).
    localparam int unsigned QW = $clog2(FIFO_DEPTH);
    // Tag FIFO pointer width; MAX_OUTSTANDING need not be a power of two.
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    // Counter width: wide enough for live + queued, which is at most 2*FIFO_DEPTH.
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    // Fetch address and request bookkeeping.
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   squash_cnt;
    logic [CW-1:0]   live_cnt;
    logic [CW-1:0]   inflight_next;

    // PC tags of accepted requests, in request order.
    logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_rd_ptr;
    logic [TW-1:0]   tag_wr_ptr;
    logic [TW-1:0]   tag_rd_next;
    logic [TW-1:0]   tag_wr_next;

    // Instruction queue.
    logic [XLEN-1:0] q_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] q_inst [FIFO_DEPTH];
    logic [QW-1:0]   q_rd_ptr;
    logic [QW-1:0]   q_wr_ptr;
    logic [CW-1:0]   q_count;

    // Handshake events for this cycle.
    logic req_fire;
    logic resp_fire;
    logic resp_keep;
    logic q_push;
    logic q_pop;

    // Queue head presentation; all of it comes straight from registered state.
    always_comb begin
        out_valid = (q_count != '0);
        out_pc    = '0;
        out_inst  = '0;
        if (out_valid) begin
            out_pc   = q_pc[q_rd_ptr];
            out_inst = q_inst[q_rd_ptr];
        end
    end

    // Issue decision and per-cycle event decode.
    always_comb begin
        live_cnt      = out_cnt - squash_cnt;
        // A request only issues if its response is guaranteed a queue slot.
        mem_req_valid = ((live_cnt + q_count) < CW'(FIFO_DEPTH)) &&
                        (out_cnt < CW'(MAX_OUTSTANDING));
        mem_req_addr  = fetch_pc;
        req_fire      = mem_req_valid && mem_req_ready;
        // Stray responses with nothing outstanding are ignored.
        resp_fire     = mem_resp_valid && (out_cnt != '0);
        resp_keep     = resp_fire && (squash_cnt == '0);
        q_push        = resp_keep && !redirect;
        q_pop         = out_valid && out_ready && !redirect;
        inflight_next = out_cnt + CW'(req_fire) - CW'(resp_fire);
        tag_rd_next   = (tag_rd_ptr == TAG_LAST) ? '0 : tag_rd_ptr + TW'(1);
        tag_wr_next   = (tag_wr_ptr == TAG_LAST) ? '0 : tag_wr_ptr + TW'(1);
    end

    // Control state: fetch PC, counters, pointers; redirect overrides all but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            out_cnt    <= '0;
            squash_cnt <= '0;
            tag_rd_ptr <= '0;
            tag_wr_ptr <= '0;
            q_rd_ptr   <= '0;
            q_wr_ptr   <= '0;
            q_count    <= '0;
        end else begin
            out_cnt <= inflight_next;
            if (req_fire) begin
                tag_wr_ptr <= tag_wr_next;
            end
            if (resp_fire) begin
                tag_rd_ptr <= tag_rd_next;
            end
            if (redirect) begin
                // Everything still owed by memory after this edge is wrong-path.
                fetch_pc   <= redirect_pc;
                squash_cnt <= inflight_next;
                q_rd_ptr   <= '0;
                q_wr_ptr   <= '0;
                q_count    <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(BYTES_PER_WORD);
                end
                if (resp_fire && (squash_cnt != '0)) begin
                    squash_cnt <= squash_cnt - CW'(1);
                end
                if (q_push) begin
                    q_wr_ptr <= q_wr_ptr + QW'(1);
                end
                if (q_pop) begin
                    q_rd_ptr <= q_rd_ptr + QW'(1);
                end
                case ({q_push, q_pop})
                    2'b10:   q_count <= q_count + CW'(1);
                    2'b01:   q_count <= q_count - CW'(1);
                    default: q_count <= q_count;
                endcase
            end
        end
    end

    // Tag storage: record the address of every accepted request.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_ptr] <= fetch_pc;
        end
    end

    // Queue storage: a kept response lands with the tag popped alongside it.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_pc[q_wr_ptr]   <= tag_mem[tag_rd_ptr];
            q_inst[q_wr_ptr] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_pq.sv
// tb_ifetch_pq: randomized and directed checks of ifetch_pq against a
// queue-level reference model (requests in flight, squash marks, output queue).
module tb_ifetch_pq;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    // Second instance for the top-of-address-space reset PC.
    logic        r2_valid;
    logic [31:0] r2_addr;
    logic        resp2_valid;
    logic [31:0] resp2_data;
    logic        o2_valid;
    logic [31:0] o2_pc;
    logic [31:0] o2_inst;
    logic        one;
    logic        zero;
    logic [31:0] zero32;

    ifetch_pq #(
        .XLEN(32), .BYTES_PER_WORD(4), .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    ifetch_pq #(
        .XLEN(32), .BYTES_PER_WORD(4), .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFF8)
    ) dut2 (
        .clk(clk), .rst(rst),
        .mem_req_valid(r2_valid), .mem_req_ready(one),
        .mem_req_addr(r2_addr),
        .mem_resp_valid(resp2_valid), .mem_resp_data(resp2_data),
        .redirect(zero), .redirect_pc(zero32),
        .out_valid(o2_valid), .out_ready(one),
        .out_pc(o2_pc), .out_inst(o2_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    typedef struct { logic [31:0] addr; bit sq; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } qe_t;
    typedef struct { logic [31:0] addr; int cyc; } mr_t;
    fl_t         m_fl[$];
    qe_t         m_q[$];
    logic [31:0] m_pc;

    // Memory-side view and logs.
    mr_t         mem_q[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_inst[$];
    int          cons_cyc[$];
    logic [31:0] log2[$];
    bit          log2_en;
    bit          acc2_prev;
    logic [31:0] acc2_addr;

    int          cyc;
    int          acc_count;
    int          rdy_pct, resp_pct, ordy_pct, redir_pm;
    bit          force_redir;
    logic [31:0] force_pc;
    bit          chk_en;

    int n_vec;
    int n_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int live_count();
        int n = 0;
        foreach (m_fl[i]) if (!m_fl[i].sq) n++;
        return n;
    endfunction

    function automatic int squashed_count();
        int n = 0;
        foreach (m_fl[i]) if (m_fl[i].sq) n++;
        return n;
    endfunction

    function automatic bit model_req_valid();
        return ((live_count() + m_q.size()) < DEPTH) && (m_fl.size() < MAXO);
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        else                           r = $urandom & 32'h0000_FFFC;
        return r;
    endfunction

    task automatic model_update(input bit r, input bit rdy, input bit rv, input logic [31:0] rd,
                                input bit rdir, input logic [31:0] rpc, input bit ordy);
        bit  rf, resp_f, pop;
        fl_t h;
        qe_t e;
        fl_t n;
        if (r) begin
            m_pc = 32'h0;
            m_fl.delete();
            m_q.delete();
            return;
        end
        rf     = model_req_valid() && rdy;
        resp_f = rv && (m_fl.size() > 0);
        pop    = (m_q.size() > 0) && ordy;
        h.addr = '0;
        h.sq   = 1'b0;
        if (resp_f) h = m_fl.pop_front();
        if (pop) void'(m_q.pop_front());
        if (resp_f && !h.sq) begin
            e.pc   = h.addr;
            e.inst = rd;
            m_q.push_back(e);
        end
        if (rf) begin
            n.addr = m_pc;
            n.sq   = 1'b0;
            m_fl.push_back(n);
            m_pc = m_pc + 32'd4;
        end
        if (rdir) begin
            m_q.delete();
            foreach (m_fl[i]) m_fl[i].sq = 1'b1;
            m_pc = rpc;
        end
    endtask

    // One clock: choose inputs, play memory, advance, update the model.
    task automatic step();
        bit          resp_v, acc, s_rst;
        logic [31:0] resp_d;
        mr_t         mr;
        resp_v = 1'b0;
        resp_d = '0;
        s_rst  = rst;
        if (!rst && mem_q.size() > 0 && mem_q[0].cyc < cyc && $urandom_range(0, 99) < resp_pct) begin
            resp_v = 1'b1;
            resp_d = mem_q[0].addr ^ MAGIC;
        end
        mem_resp_valid = resp_v;
        mem_resp_data  = resp_d;
        mem_req_ready  = ($urandom_range(0, 99) < rdy_pct);
        out_ready      = ($urandom_range(0, 99) < ordy_pct);
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
        end else begin
            redirect    = ($urandom_range(0, 999) < redir_pm);
            redirect_pc = rand_pc();
        end
        if (resp_v) void'(mem_q.pop_front());
        acc = (mem_req_valid === 1'b1) && mem_req_ready;
        if (acc && !rst) begin
            mr.addr = mem_req_addr;
            mr.cyc  = cyc;
            mem_q.push_back(mr);
            acc_count++;
        end
        if (rst) mem_q.delete();
        if (!rst && out_valid === 1'b1 && out_ready) begin
            cons_pc.push_back(out_pc);
            cons_inst.push_back(out_inst);
            cons_cyc.push_back(cyc);
        end
        resp2_valid = acc2_prev;
        resp2_data  = acc2_addr ^ MAGIC;
        if (log2_en && !rst && r2_valid === 1'b1 && log2.size() < 3) log2.push_back(r2_addr);
        acc2_prev = !rst && (r2_valid === 1'b1);
        acc2_addr = r2_addr;
        @(posedge clk);
        #1;
        model_update(s_rst, mem_req_ready, resp_v, resp_d, redirect, redirect_pc, out_ready);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        cons_pc.delete();
        cons_inst.delete();
        cons_cyc.delete();
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, model_req_valid()});
            check("mem_req_addr", mem_req_addr, m_pc);
            check("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() > 0)});
            if (m_q.size() > 0) begin
                check("out_pc", out_pc, m_q[0].pc);
                check("out_inst", out_inst, m_q[0].inst);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int hits;
        int rc;
        n_vec = 0; n_miss = 0; cyc = 0; acc_count = 0;
        one = 1'b1; zero = 1'b0; zero32 = '0;
        rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        resp2_valid = 1'b0; resp2_data = '0; acc2_prev = 1'b0; acc2_addr = '0;
        log2_en = 1'b0; force_redir = 1'b0; force_pc = '0; chk_en = 1'b0;
        rdy_pct = 100; resp_pct = 100; ordy_pct = 100; redir_pm = 0;

        // Reset state and straight-line streaming.
        do_reset();
        chk_en  = 1'b1;
        log2_en = 1'b1;
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        clear_logs();
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 3; i++) begin
            check("stream_pc", (cons_pc.size() > i) ? cons_pc[i] : 32'hDEAD_BEEF, 32'(i * 4));
            check("stream_inst", (cons_inst.size() > i) ? cons_inst[i] : 32'hDEAD_BEEF, 32'(i * 4) ^ MAGIC);
        end
        check("stream_gap01", (cons_cyc.size() > 1) ? 32'(cons_cyc[1] - cons_cyc[0]) : 32'hFFFF, 32'd1);
        check("stream_gap12", (cons_cyc.size() > 2) ? 32'(cons_cyc[2] - cons_cyc[1]) : 32'hFFFF, 32'd1);
        check("wrap_addr0", (log2.size() > 0) ? log2[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("wrap_addr1", (log2.size() > 1) ? log2[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_addr2", (log2.size() > 2) ? log2[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Decode stalled: the queue limits fetch to FIFO_DEPTH requests.
        do_reset();
        ordy_pct = 0;
        acc_count = 0;
        for (int i = 0; i < 20; i++) step();
        check("stall_accepted", 32'(acc_count), 32'd4);
        check("stall_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("stall_head_pc", out_pc, 32'h0);
        ordy_pct = 100;
        clear_logs();
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 6; i++)
            check("drain_pc", (cons_pc.size() > i) ? cons_pc[i] : 32'hDEAD_BEEF, 32'(i * 4));

        // Two requests (0x10, 0x14) in flight when a redirect arrives.
        do_reset();
        guard = 0;
        while (mem_req_addr !== 32'h10 && guard < 40) begin
            step();
            guard++;
        end
        check("reach_0x10", mem_req_addr, 32'h10);
        rdy_pct = 0;
        for (int i = 0; i < 3; i++) step();
        rdy_pct = 100; resp_pct = 0;
        for (int i = 0; i < 3; i++) step();
        check("two_out_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("two_out_cnt", 32'(dut.out_cnt), 32'd2);
        rdy_pct = 0; force_redir = 1'b1; force_pc = 32'h200;
        step();
        force_redir = 1'b0;
        check("redir_out_valid", {31'b0, out_valid}, 32'd0);
        check("redir_addr", mem_req_addr, 32'h200);
        check("redir_squash", 32'(dut.squash_cnt), 32'd2);
        rdy_pct = 100; resp_pct = 100;
        clear_logs();
        for (int i = 0; i < 10; i++) step();
        check("redir_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hDEAD_BEEF, 32'h200);
        check("redir_first_inst", (cons_inst.size() > 0) ? cons_inst[0] : 32'hDEAD_BEEF, 32'hA5A5_0200);
        hits = 0;
        foreach (cons_pc[i]) if (cons_pc[i] == 32'h10 || cons_pc[i] == 32'h14) hits++;
        check("squashed_seen", 32'(hits), 32'd0);

        // Redirect coinciding with a response and a pop in steady streaming.
        do_reset();
        for (int i = 0; i < 6; i++) step();
        force_redir = 1'b1; force_pc = 32'h300;
        rc = cyc;
        step();
        force_redir = 1'b0;
        check("coinc_out_valid", {31'b0, out_valid}, 32'd0);
        check("coinc_addr", mem_req_addr, 32'h300);
        check("coinc_squash", 32'(dut.squash_cnt), 32'd1);
        check("coinc_squash_model", 32'(dut.squash_cnt), 32'(squashed_count()));
        clear_logs();
        for (int i = 0; i < 6; i++) step();
        check("coinc_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hDEAD_BEEF, 32'h300);
        check("coinc_latency", (cons_cyc.size() > 0) ? 32'(cons_cyc[0] - rc) : 32'hFFFF, 32'd3);

        // Reset while requests are outstanding and the queue is occupied.
        do_reset();
        ordy_pct = 0;
        guard = 0;
        while (m_q.size() < 2 && guard < 40) begin
            step();
            guard++;
        end
        resp_pct = 0;
        for (int i = 0; i < 3; i++) step();
        check("pre_rst_out_cnt", 32'(dut.out_cnt), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("mid_rst_addr", mem_req_addr, 32'h0);
        check("mid_rst_out_cnt", 32'(dut.out_cnt), 32'd0);
        check("mid_rst_squash", 32'(dut.squash_cnt), 32'd0);
        check("mid_rst_q_count", 32'(dut.q_count), 32'd0);
        resp_pct = 100; ordy_pct = 100;

        // Randomized traffic with redirects and occasional resets.
        for (int b = 0; b < 30; b++) begin
            rdy_pct  = $urandom_range(30, 100);
            resp_pct = $urandom_range(20, 100);
            ordy_pct = $urandom_range(10, 100);
            redir_pm = $urandom_range(0, 60);
            for (int i = 0; i < 100; i++) begin
                rst = ($urandom_range(0, 999) < 3);
                step();
            end
        end
        rst = 1'b0;
        redir_pm = 0;
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
